// File: rtl/cs_pkg.sv
// Shared types and defaults for the writable control store and its load/readback engine.
package cs_pkg;

  localparam int unsigned CS_UW = 64;
  localparam int unsigned CS_DW = 16;
  localparam int unsigned CS_AW = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT,
    ST_RB_READ,
    ST_RB_SEND,
    ST_FINISH
  } cs_eng_state_t;

  // Number of IDB segments per microword.
  function automatic int unsigned nseg(input int unsigned uw, input int unsigned dw);
    return uw / dw;
  endfunction

endpackage

// File: rtl/cs_wcs_engine_if.sv
// Microsequencer fetch port plus IDB command/load/readback handshakes of the control store.
interface cs_wcs_engine_if
  import cs_pkg::*;
#(
  parameter int unsigned UW = CS_UW,
  parameter int unsigned DW = CS_DW,
  parameter int unsigned AW = CS_AW
);

  logic          fetch_en;
  logic [AW-1:0] lua;
  logic [UW-1:0] csbits;
  logic          csbits_vld;
  logic          cmd_start;
  logic          cmd_rd;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic [DW-1:0] ld_data;
  logic          ld_vld;
  logic          ld_rdy;
  logic [DW-1:0] rb_data;
  logic          rb_vld;
  logic          rb_rdy;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output fetch_en, lua, cmd_start, cmd_rd, cmd_addr, cmd_len, ld_data, ld_vld, rb_rdy,
    input  csbits, csbits_vld, ld_rdy, rb_data, rb_vld, busy, done, err
  );

  modport slave (
    input  fetch_en, lua, cmd_start, cmd_rd, cmd_addr, cmd_len, ld_data, ld_vld, rb_rdy,
    output csbits, csbits_vld, ld_rdy, rb_data, rb_vld, busy, done, err
  );

endinterface

// File: rtl/cs_wcs_ram.sv
// Control store array: one write port, one synchronous read-before-write read port.
// The read lands in one of two output registers so fetches never disturb a pending readback word.
module cs_wcs_ram #(
  parameter int unsigned W  = 64,
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic          rsel,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata_a,
  output logic [W-1:0]  rdata_b
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output registers reset; the array itself is never reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (re) begin
      if (rsel) rdata_a <= mem[raddr];
      else      rdata_b <= mem[raddr];
    end
  end

endmodule

// File: rtl/cs_wcs_engine.sv
// Writable control store: 1-cycle microword fetch plus a segmented burst load/readback engine.
module cs_wcs_engine
  import cs_pkg::*;
#(
  parameter int unsigned UW = CS_UW,
  parameter int unsigned DW = CS_DW,
  parameter int unsigned AW = CS_AW
) (
  input  logic           sysclk,
  input  logic           sys_rst,
  cs_wcs_engine_if.slave bus
);

  localparam int unsigned NSEG = nseg(UW, DW);
  localparam int unsigned SW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  cs_eng_state_t state_q, state_nxt;
  logic [AW-1:0] addr_q, len_q, cnt_q;
  logic [SW-1:0] seg_q;
  logic [UW-1:0] asm_q, rb_word;
  logic [DW-1:0] rb_data_c;
  logic          err_q, busy_q, done_q, ld_rdy_q, rb_vld_q, csbits_vld_q;
  logic          ld_rdy_d, rb_vld_d, done_d, busy_d;
  logic          seg_last_c, last_c, ld_hs_c, rb_hs_c, adv_c, we_c, rb_rd_c;

  assign seg_last_c = (seg_q == SW'(NSEG - 1));
  assign last_c     = (cnt_q == len_q);
  assign ld_hs_c    = (state_q == ST_LOAD) && bus.ld_vld;
  assign rb_hs_c    = (state_q == ST_RB_SEND) && bus.rb_rdy;
  assign we_c       = (state_q == ST_COMMIT);
  assign rb_rd_c    = (state_q == ST_RB_READ) && !bus.fetch_en;
  assign adv_c      = !last_c && (we_c || (rb_hs_c && seg_last_c));

  cs_wcs_ram #(.W(UW), .AW(AW)) u_ram (
    .clk     (sysclk),
    .rst     (sys_rst),
    .we      (we_c),
    .waddr   (addr_q),
    .wdata   (asm_q),
    .re      (bus.fetch_en | rb_rd_c),
    .rsel    (bus.fetch_en),
    .raddr   (bus.fetch_en ? bus.lua : addr_q),
    .rdata_a (bus.csbits),
    .rdata_b (rb_word)
  );

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE:    if (bus.cmd_start) state_nxt = bus.cmd_rd ? ST_RB_READ : ST_LOAD;
      ST_LOAD:    if (bus.ld_vld && seg_last_c) state_nxt = ST_COMMIT;
      ST_COMMIT:  state_nxt = last_c ? ST_FINISH : ST_LOAD;
      ST_RB_READ: if (!bus.fetch_en) state_nxt = ST_RB_SEND;
      ST_RB_SEND: if (bus.rb_rdy && seg_last_c) state_nxt = last_c ? ST_FINISH : ST_RB_READ;
      ST_FINISH:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Handshake/status outputs are decoded from the next state and registered below.
  always_comb begin
    ld_rdy_d = (state_nxt == ST_LOAD);
    rb_vld_d = (state_nxt == ST_RB_SEND);
    done_d   = (state_nxt == ST_FINISH);
    busy_d   = (state_nxt inside {ST_LOAD, ST_COMMIT, ST_RB_READ, ST_RB_SEND});
  end

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      ld_rdy_q     <= 1'b0;
      rb_vld_q     <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      csbits_vld_q <= 1'b0;
    end else begin
      ld_rdy_q     <= ld_rdy_d;
      rb_vld_q     <= rb_vld_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      csbits_vld_q <= bus.fetch_en;
    end
  end

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      seg_q  <= '0;
      asm_q  <= '0;
      err_q  <= 1'b0;
    end else if ((state_q == ST_IDLE) && bus.cmd_start) begin
      addr_q <= bus.cmd_addr;
      len_q  <= bus.cmd_len;
      cnt_q  <= '0;
      seg_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (ld_hs_c || rb_hs_c) seg_q <= seg_last_c ? '0 : seg_q + SW'(1);
      for (int k = 0; k < NSEG; k++) begin
        if (ld_hs_c && (seg_q == SW'(k))) asm_q[k*DW +: DW] <= bus.ld_data;
      end
      // Wrapping past the top of the store is flagged but the session carries on.
      if (adv_c) begin
        addr_q <= addr_q + AW'(1);
        cnt_q  <= cnt_q + AW'(1);
        if (&addr_q) err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rb_data_c = '0;
    for (int k = 0; k < NSEG; k++) begin
      if (seg_q == SW'(k)) rb_data_c = rb_word[k*DW +: DW];
    end
  end

  assign bus.rb_data    = rb_data_c;
  assign bus.ld_rdy     = ld_rdy_q;
  assign bus.rb_vld     = rb_vld_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.csbits_vld = csbits_vld_q;

endmodule
